// File: rtl/gdm_pkg.sv
// Shared constants, FSM encoding and address helper for the gdm fetch port.
// The PREF state exists only when GDM_FETCH_PREFETCH_EN is defined.
package gdm_pkg;

  localparam int GDM_TAG_W           = 30;
  localparam int GDM_DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1
`ifdef GDM_FETCH_PREFETCH_EN
    , PREF = 2'd2
`endif
  } gdm_state_e;

  function automatic logic [31:0] gdm_word_addr(input logic [GDM_TAG_W-1:0] tag);
    return {tag, 2'b00};
  endfunction

endpackage

// File: rtl/gdm_buf_entry.sv
// One buffered instruction word: valid/tag/data register with tag compare.
// A global invalidate overrides a same-cycle load; the data is still written.
module gdm_buf_entry
  import gdm_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 inv,
  input  logic                 load,
  input  logic                 clear,
  input  logic [GDM_TAG_W-1:0] load_tag,
  input  logic [31:0]          load_data,
  input  logic [GDM_TAG_W-1:0] lookup_tag,
  output logic                 hit,
  output logic [31:0]          data
);

  logic                 valid_q, valid_d;
  logic [GDM_TAG_W-1:0] tag_q, tag_d;
  logic [31:0]          data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      tag_d   = load_tag;
      data_d  = load_data;
    end else if (clear) begin
      valid_d = 1'b0;
    end
    if (inv) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign hit  = valid_q && (tag_q == lookup_tag);
  assign data = data_q;

endmodule

// File: rtl/gdm_fetch_port.sv
// Fetch-side word buffer in front of a slow backing memory, with timeout.
// Define GDM_FETCH_PREFETCH_EN to add a next-word prefetch entry and PREF state.
module gdm_fetch_port
  import gdm_pkg::*;
#(
  parameter int TIMEOUT = GDM_DEFAULT_TIMEOUT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_gdm_en,
  input  logic [31:0] if_gdm_addr,
  output logic [31:0] gdm_if_data,
  output logic        gdm_if_ready,
  input  logic        gdm_inv,
  output logic        gdm_mem_req,
  output logic [31:0] gdm_mem_addr,
  input  logic        gdm_mem_ack,
  input  logic [31:0] gdm_mem_rdata,
  output logic        gdm_err
);

  localparam int             CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  gdm_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic                 err_q, err_d;

  logic [GDM_TAG_W-1:0] fetch_tag;
  logic [GDM_TAG_W-1:0] req_tag;
  logic                 unused_lsbs;

  logic                 d_hit;
  logic [31:0]          d_data;
  logic                 d_load;
  logic [GDM_TAG_W-1:0] d_load_tag;
  logic [31:0]          d_load_data;
  logic                 any_hit;

  assign fetch_tag   = if_gdm_addr[31:2];
  assign req_tag     = mem_addr_q[31:2];
  assign unused_lsbs = ^if_gdm_addr[1:0];

  gdm_buf_entry u_demand (
    .clock      (clock),
    .reset      (reset),
    .inv        (gdm_inv),
    .load       (d_load),
    .clear      (1'b0),
    .load_tag   (d_load_tag),
    .load_data  (d_load_data),
    .lookup_tag (fetch_tag),
    .hit        (d_hit),
    .data       (d_data)
  );

`ifdef GDM_FETCH_PREFETCH_EN
  logic        p_hit;
  logic [31:0] p_data;
  logic        p_load;
  logic        p_clear;

  gdm_buf_entry u_prefetch (
    .clock      (clock),
    .reset      (reset),
    .inv        (gdm_inv),
    .load       (p_load),
    .clear      (p_clear),
    .load_tag   (req_tag),
    .load_data  (gdm_mem_rdata),
    .lookup_tag (fetch_tag),
    .hit        (p_hit),
    .data       (p_data)
  );

  assign any_hit     = d_hit | p_hit;
  assign gdm_mem_req = (state_q == REQ) || (state_q == PREF);
`else
  assign any_hit     = d_hit;
  assign gdm_mem_req = (state_q == REQ);
`endif

  assign gdm_if_ready = reset & if_gdm_en & any_hit;
  assign gdm_mem_addr = mem_addr_q;
  assign gdm_err      = err_q;

  always_comb begin
    gdm_if_data = '0;
    if (gdm_if_ready) begin
`ifdef GDM_FETCH_PREFETCH_EN
      gdm_if_data = d_hit ? d_data : p_data;
`else
      gdm_if_data = d_data;
`endif
    end
  end

  // A request ends on ack (fill) or when the count would reach TIMEOUT without one.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    err_d       = err_q;
    d_load      = 1'b0;
    d_load_tag  = req_tag;
    d_load_data = gdm_mem_rdata;
`ifdef GDM_FETCH_PREFETCH_EN
    p_load      = 1'b0;
    p_clear     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (if_gdm_en && !any_hit) begin
          state_d    = REQ;
          cnt_d      = '0;
          mem_addr_d = gdm_word_addr(fetch_tag);
        end
`ifdef GDM_FETCH_PREFETCH_EN
        else if (if_gdm_en && !d_hit && p_hit) begin
          // Promote the prefetched word and run ahead to the following one.
          d_load      = 1'b1;
          d_load_tag  = fetch_tag;
          d_load_data = p_data;
          p_clear     = 1'b1;
          if (fetch_tag != '1) begin
            state_d    = PREF;
            cnt_d      = '0;
            mem_addr_d = gdm_word_addr(fetch_tag + GDM_TAG_W'(1));
          end
        end
`endif
      end
      REQ: begin
        if (gdm_mem_ack) begin
          d_load  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
`ifdef GDM_FETCH_PREFETCH_EN
          if (req_tag != '1) begin
            state_d    = PREF;
            mem_addr_d = gdm_word_addr(req_tag + GDM_TAG_W'(1));
          end
`endif
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef GDM_FETCH_PREFETCH_EN
      PREF: begin
        if (gdm_mem_ack) begin
          p_load  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_gdm_fetch_port.sv
// Scoreboard bench for gdm_fetch_port: expected hit data and memory request
// addresses are queued by the stimulus and consumed by a negedge monitor.
module tb_gdm_fetch_port;

  localparam int TIMEOUT = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        if_gdm_en = 1'b0;
  logic [31:0] if_gdm_addr = '0;
  logic [31:0] gdm_if_data;
  logic        gdm_if_ready;
  logic        gdm_inv = 1'b0;
  logic        gdm_mem_req;
  logic [31:0] gdm_mem_addr;
  logic        gdm_mem_ack = 1'b0;
  logic [31:0] gdm_mem_rdata = '0;
  logic        gdm_err;

  int num_checks = 0;
  int num_fails  = 0;

  logic [31:0] exp_data_q[$];
  logic [31:0] exp_addr_q[$];

  logic        prev_req  = 1'b0;
  logic [31:0] prev_addr = '0;

  always #5 clock = ~clock;

  gdm_fetch_port #(.TIMEOUT(TIMEOUT)) dut (
    .clock         (clock),
    .reset         (reset),
    .if_gdm_en     (if_gdm_en),
    .if_gdm_addr   (if_gdm_addr),
    .gdm_if_data   (gdm_if_data),
    .gdm_if_ready  (gdm_if_ready),
    .gdm_inv       (gdm_inv),
    .gdm_mem_req   (gdm_mem_req),
    .gdm_mem_addr  (gdm_mem_addr),
    .gdm_mem_ack   (gdm_mem_ack),
    .gdm_mem_rdata (gdm_mem_rdata),
    .gdm_err       (gdm_err)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, return before the falling edge.
  task automatic applyStimulus(input logic rst_n, input logic en, input logic [31:0] addr,
                               input logic ack, input logic [31:0] rdata, input logic inv);
    @(posedge clock);
    #1;
    reset         = rst_n;
    if_gdm_en     = en;
    if_gdm_addr   = addr;
    gdm_mem_ack   = ack;
    gdm_mem_rdata = rdata;
    gdm_inv       = inv;
    #3;
  endtask

  // Monitor: every ready cycle consumes one expected word; every new request one expected address.
  always @(negedge clock) begin
    if (gdm_if_ready === 1'b1) begin
      if (exp_data_q.size() == 0) begin
        num_checks++;
        num_fails++;
        $display("[TB] FAIL unexpected_hit: got data 0x%08h, expected no hit", gdm_if_data);
      end else begin
        checkOutput("hit_data", gdm_if_data, exp_data_q.pop_front());
      end
    end
    if (gdm_mem_req === 1'b1 && (!prev_req || gdm_mem_addr !== prev_addr)) begin
      if (exp_addr_q.size() == 0) begin
        num_checks++;
        num_fails++;
        $display("[TB] FAIL unexpected_req: got addr 0x%08h, expected no request", gdm_mem_addr);
      end else begin
        checkOutput("req_addr", gdm_mem_addr, exp_addr_q.pop_front());
      end
    end
    prev_req  = (gdm_mem_req === 1'b1);
    prev_addr = gdm_mem_addr;
  end

  // Global time limit so a stuck run still reports.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
    repeat (2) begin
      applyStimulus(1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
      checkOutput("rst_ready", {31'd0, gdm_if_ready}, 32'd0);
      checkOutput("rst_data", gdm_if_data, 32'd0);
      checkOutput("rst_req", {31'd0, gdm_mem_req}, 32'd0);
      checkOutput("rst_addr", gdm_mem_addr, 32'd0);
      checkOutput("rst_err", {31'd0, gdm_err}, 32'd0);
    end

`ifdef GDM_FETCH_PREFETCH_EN
    exp_addr_q.push_back(32'h200);
    exp_addr_q.push_back(32'h204);
    applyStimulus(1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
    checkOutput("pf_miss_ready", {31'd0, gdm_if_ready}, 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h200, 1'b1, 32'hA0A0A0A0, 1'b0);
    exp_data_q.push_back(32'hA0A0A0A0);
    applyStimulus(1'b1, 1'b1, 32'h200, 1'b1, 32'hB0B0B0B0, 1'b0);
    checkOutput("pf_req", {31'd0, gdm_mem_req}, 32'd1);
    checkOutput("pf_addr", gdm_mem_addr, 32'h204);
    exp_data_q.push_back(32'hB0B0B0B0);
    exp_addr_q.push_back(32'h208);
    applyStimulus(1'b1, 1'b1, 32'h204, 1'b0, 32'h0, 1'b0);
    checkOutput("pf_hit_ready", {31'd0, gdm_if_ready}, 32'd1);
    checkOutput("pf_hit_no_req", {31'd0, gdm_mem_req}, 32'd0);
    exp_data_q.push_back(32'hB0B0B0B0);
    applyStimulus(1'b1, 1'b1, 32'h204, 1'b1, 32'hC0C0C0C0, 1'b0);
    checkOutput("pf_next_req", {31'd0, gdm_mem_req}, 32'd1);
    checkOutput("pf_next_addr", gdm_mem_addr, 32'h208);
`else
    // Basic miss: three REQ cycles, ack on the third, hit afterwards.
    exp_addr_q.push_back(32'h100);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 32'h100, (i == 3), (i == 3) ? 32'hDEADBEEF : 32'h0, 1'b0);
      checkOutput("miss_ready", {31'd0, gdm_if_ready}, 32'd0);
      if (i > 0) begin
        checkOutput("miss_req", {31'd0, gdm_mem_req}, 32'd1);
        checkOutput("miss_addr", gdm_mem_addr, 32'h100);
      end
    end
    exp_data_q.push_back(32'hDEADBEEF);
    applyStimulus(1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
    checkOutput("fill_ready", {31'd0, gdm_if_ready}, 32'd1);
    checkOutput("fill_req", {31'd0, gdm_mem_req}, 32'd0);
    exp_data_q.push_back(32'hDEADBEEF);
    applyStimulus(1'b1, 1'b1, 32'h102, 1'b0, 32'h0, 1'b0);
    checkOutput("rehit_ready", {31'd0, gdm_if_ready}, 32'd1);
    checkOutput("rehit_req", {31'd0, gdm_mem_req}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("idle_ready", {31'd0, gdm_if_ready}, 32'd0);
    checkOutput("idle_req", {31'd0, gdm_mem_req}, 32'd0);

    // Invalidate coinciding with ack: the word must be refetched.
    exp_addr_q.push_back(32'h300);
    applyStimulus(1'b1, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0);
    checkOutput("inv_miss_ready", {31'd0, gdm_if_ready}, 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h300, 1'b1, 32'h11112222, 1'b1);
    checkOutput("inv_req", {31'd0, gdm_mem_req}, 32'd1);
    exp_addr_q.push_back(32'h300);
    applyStimulus(1'b1, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0);
    checkOutput("inv_remiss_ready", {31'd0, gdm_if_ready}, 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h300, 1'b1, 32'h33334444, 1'b0);
    checkOutput("inv_rereq", {31'd0, gdm_mem_req}, 32'd1);
    exp_data_q.push_back(32'h33334444);
    applyStimulus(1'b1, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0);
    checkOutput("inv_refill_ready", {31'd0, gdm_if_ready}, 32'd1);

    // Ack in the last allowed cycle is accepted without error.
    exp_addr_q.push_back(32'h500);
    applyStimulus(1'b1, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 32'h500, (i == 3), 32'h77778888, 1'b0);
      checkOutput("late_ack_req", {31'd0, gdm_mem_req}, 32'd1);
    end
    exp_data_q.push_back(32'h77778888);
    applyStimulus(1'b1, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0);
    checkOutput("late_ack_ready", {31'd0, gdm_if_ready}, 32'd1);
    checkOutput("late_ack_err", {31'd0, gdm_err}, 32'd0);

    // No ack: request held for TIMEOUT cycles, sticky error, then a normal retry.
    exp_addr_q.push_back(32'h400);
    applyStimulus(1'b1, 1'b1, 32'h400, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      checkOutput("to_req_high", {31'd0, gdm_mem_req}, 32'd1);
    end
    exp_addr_q.push_back(32'h400);
    applyStimulus(1'b1, 1'b1, 32'h400, 1'b0, 32'h0, 1'b0);
    checkOutput("to_req_low", {31'd0, gdm_mem_req}, 32'd0);
    checkOutput("to_err", {31'd0, gdm_err}, 32'd1);
    checkOutput("to_ready", {31'd0, gdm_if_ready}, 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h400, 1'b1, 32'h55556666, 1'b0);
    checkOutput("retry_req", {31'd0, gdm_mem_req}, 32'd1);
    exp_data_q.push_back(32'h55556666);
    applyStimulus(1'b1, 1'b1, 32'h400, 1'b0, 32'h0, 1'b0);
    checkOutput("retry_ready", {31'd0, gdm_if_ready}, 32'd1);
    checkOutput("err_sticky", {31'd0, gdm_err}, 32'd1);
`endif

    // Reset in the middle of a request; the late ack must be ignored.
    exp_addr_q.push_back(32'h600);
    applyStimulus(1'b1, 1'b1, 32'h600, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h600, 1'b0, 32'h0, 1'b0);
    checkOutput("mid_req", {31'd0, gdm_mem_req}, 32'd1);
    applyStimulus(1'b0, 1'b1, 32'h600, 1'b0, 32'h0, 1'b0);
    checkOutput("mid_rst_ready", {31'd0, gdm_if_ready}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'h9999AAAA, 1'b0);
    checkOutput("post_rst_req", {31'd0, gdm_mem_req}, 32'd0);
    checkOutput("post_rst_addr", gdm_mem_addr, 32'h0);
    checkOutput("post_rst_err", {31'd0, gdm_err}, 32'd0);
    exp_addr_q.push_back(32'h600);
    applyStimulus(1'b1, 1'b1, 32'h600, 1'b0, 32'h0, 1'b0);
    checkOutput("post_rst_miss", {31'd0, gdm_if_ready}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("post_rst_rereq", {31'd0, gdm_mem_req}, 32'd1);

    @(negedge clock);
    #1;
    checkOutput("data_queue_empty", exp_data_q.size(), 32'd0);
    checkOutput("addr_queue_empty", exp_addr_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
